// File: rtl/led_matrix_scan_pkg.sv
// Shared types and constants for the 8x8 LED matrix row-scan driver.
// Holds the matrix geometry, scan state encoding and row-write bundle.
`ifndef MATRIX_SIZE
`define MATRIX_SIZE 8
`endif

package led_matrix_scan_pkg;

    localparam int MATRIX_SIZE = `MATRIX_SIZE;
    localparam int ROW_W       = 3;
    localparam int NUM_ROWS    = 1 << ROW_W;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BLANK   = 2'd1;
    localparam logic [1:0] DISPLAY = 2'd2;

    typedef logic [ROW_W-1:0]       row_t;
    typedef logic [MATRIX_SIZE-1:0] col_t;

    typedef struct packed {
        row_t row;
        col_t data;
        logic last;
    } row_wr_t;

    function automatic row_t next_row(row_t r);
        return r + 1'b1;
    endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Row-write valid/ready channel into the LED matrix frame store.
// The writer drives master; the scan driver takes slave.
interface led_matrix_scan_if;
    import led_matrix_scan_pkg::*;

    logic wr_valid_i;
    logic wr_ready_o;
    row_t wr_row_i;
    col_t wr_data_i;
    logic wr_last_i;

    modport master (
        output wr_valid_i,
        output wr_row_i,
        output wr_data_i,
        output wr_last_i,
        input  wr_ready_o
    );

    modport slave (
        input  wr_valid_i,
        input  wr_row_i,
        input  wr_data_i,
        input  wr_last_i,
        output wr_ready_o
    );

endinterface

// File: rtl/led_frame_buffer.sv
// Ping-pong frame store: one bank is shown, the other takes writes.
// Swapping flips the pointer; the new back bank keeps stale rows.
module led_frame_buffer
    import led_matrix_scan_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic wr_en_i,
    input  row_t wr_row_i,
    input  col_t wr_data_i,
    input  logic swap_i,
    input  row_t rd_row_i,
    output col_t rd_data_o
);

    logic [1:0][NUM_ROWS-1:0][MATRIX_SIZE-1:0] bank;
    logic                                      disp_sel;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bank     <= '0;
            disp_sel <= 1'b0;
        end else begin
            if (swap_i) begin
                disp_sel <= ~disp_sel;
            end
            if (wr_en_i) begin
                bank[~disp_sel][wr_row_i] <= wr_data_i;
            end
        end
    end

    assign rd_data_o = bank[disp_sel][rd_row_i];

endmodule

// File: rtl/led_matrix_scan.sv
// Row-scan driver for the 8x8 LED matrix feeding a 3-to-8 decoder.
// Blank/dwell FSM, tear-free frame swap and row-write handshake.
module led_matrix_scan
    import led_matrix_scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            scan_en_i,
    led_matrix_scan_if.slave wr,
    output row_t            row_sel_o,
    output logic            decoder_en_o,
    output col_t            col_data_o,
    output logic            frame_start_o
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ?
                             DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    row_t             row;
    row_t             row_nxt;
    logic             pending;
    logic             pending_nxt;
    logic             ready_q;

    row_wr_t wr_req;
    logic    wr_acc;
    logic    blank_end;
    logic    dwell_end;
    logic    wrap;
    logic    swap;
    logic    enter_disp;
    col_t    rd_data;

    assign wr_req = '{
        row:  wr.wr_row_i,
        data: wr.wr_data_i,
        last: wr.wr_last_i
    };

    assign wr_acc        = wr.wr_valid_i && ready_q;
    assign wr.wr_ready_o = ready_q;

    assign blank_end  = (state == BLANK) && (cnt == BLANK_LAST);
    assign dwell_end  = (state == DISPLAY) && (cnt == DWELL_LAST);
    assign wrap       = dwell_end && (row == row_t'(NUM_ROWS - 1));
    assign enter_disp = scan_en_i && blank_end;

    // A commit accepted on the wrap edge cannot also swap: it only
    // becomes pending on that edge, so it waits for the next wrap.
    assign swap = pending && ((state == IDLE) || wrap);

    always_comb begin
        pending_nxt = pending;
        if (swap) begin
            pending_nxt = 1'b0;
        end else if (wr_acc && wr_req.last) begin
            pending_nxt = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        row_nxt   = row;
        if (!scan_en_i) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            row_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    row_nxt   = '0;
                end
                BLANK: begin
                    if (blank_end) begin
                        state_nxt = DISPLAY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                DISPLAY: begin
                    if (dwell_end) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        row_nxt   = next_row(row);
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    row_nxt   = '0;
                end
            endcase
        end
    end

    led_frame_buffer u_fb (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_i   (wr_acc),
        .wr_row_i  (wr_req.row),
        .wr_data_i (wr_req.data),
        .swap_i    (swap),
        .rd_row_i  (row),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            cnt           <= '0;
            row           <= '0;
            pending       <= 1'b0;
            ready_q       <= 1'b1;
            decoder_en_o  <= 1'b0;
            col_data_o    <= '0;
            frame_start_o <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            row           <= row_nxt;
            pending       <= pending_nxt;
            ready_q       <= !pending_nxt;
            decoder_en_o  <= (state_nxt == DISPLAY);
            frame_start_o <= enter_disp && (row == '0);
            // Column data is latched once per row so it is stable
            // for the whole dwell and valid as the enable rises.
            if (enter_disp) begin
                col_data_o <= rd_data;
            end else if (state_nxt != DISPLAY) begin
                col_data_o <= '0;
            end
        end
    end

    assign row_sel_o = row;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with DWELL=4, BLANK=2.
// Expected outputs come from a cycle-position model of the scan.
module tb_led_matrix_scan;
    import led_matrix_scan_pkg::*;

    localparam int DW = 4;
    localparam int BL = 2;
    localparam int RP = DW + BL;
    localparam int FP = 8 * RP;

    logic clk = 1'b0;
    logic rst_n;
    logic scan_en;
    row_t row_sel;
    logic dec_en;
    col_t col;
    logic fs;

    int n_chk = 0;
    int n_fail = 0;

    logic [13:0] obs;

    led_matrix_scan_if wif ();

    led_matrix_scan #(
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .scan_en_i     (scan_en),
        .wr            (wif),
        .row_sel_o     (row_sel),
        .decoder_en_o  (dec_en),
        .col_data_o    (col),
        .frame_start_o (fs)
    );

    always #5 clk = ~clk;

    // {row_sel, decoder_en, col_data, frame_start, wr_ready}
    assign obs = {row_sel, dec_en, col, fs, wif.wr_ready_o};

    function automatic row_t m_row(int c);
        return row_t'((c / RP) % 8);
    endfunction

    function automatic logic [13:0] m_out(int c, col_t d, logic rdy);
        logic lit;
        logic f;
        lit = (c % RP) >= BL;
        f   = lit && ((c % RP) == BL) && (m_row(c) == 3'd0);
        return {m_row(c), lit, lit ? d : 8'h00, f, rdy};
    endfunction

    function automatic col_t a_pat(int r);
        return col_t'(8'h01 << r);
    endfunction

    function automatic col_t b_pat(int r);
        return 8'hF0 ^ col_t'(r);
    endfunction

    function automatic col_t c_pat(int r);
        return (r == 2) ? 8'h5A : a_pat(r);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(logic v, row_t r, col_t d, logic l);
        wif.wr_valid_i = v;
        wif.wr_row_i   = r;
        wif.wr_data_i  = d;
        wif.wr_last_i  = l;
    endtask

    task automatic start_scan();
        scan_en = 1'b0;
        step();
        scan_en = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        scan_en = 1'b0;
        drive_wr(1'b0, '0, '0, 1'b0);
        #12;
        n_chk++;
        if (obs !== 14'h0001) begin
            n_fail++;
            $display("FAIL reset_hold got %h want %h", obs, 14'h0001);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_chk++;
        if (obs !== 14'h0001) begin
            n_fail++;
            $display("FAIL reset_release got %h want %h", obs, 14'h0001);
        end
    endtask

    task automatic test_scan();
        logic [13:0] want;
        start_scan();
        for (int c = 0; c < FP + 8; c++) begin
            step();
            want = m_out(c, 8'h00, 1'b1);
            n_chk++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL scan c=%0d got %h want %h", c, obs, want);
            end
        end
    endtask

    task automatic test_frame_write();
        logic [13:0] want;
        col_t        d;
        logic        rdy;
        start_scan();
        for (int c = 0; c < 2 * FP + 4; c++) begin
            step();
            d    = (c >= FP) ? a_pat(m_row(c)) : 8'h00;
            rdy  = !(c >= 25 && c < FP);
            want = m_out(c, d, rdy);
            n_chk++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL frame_write c=%0d got %h want %h",
                         c, obs, want);
            end
            if (c >= 17 && c <= 24) begin
                drive_wr(1'b1, row_t'(c - 17), a_pat(c - 17), c == 24);
            end else begin
                drive_wr(1'b0, '0, '0, 1'b0);
            end
        end
    endtask

    task automatic test_commit_on_wrap();
        logic [13:0] want;
        col_t        d;
        logic        rdy;
        start_scan();
        for (int c = 0; c < 3 * FP; c++) begin
            step();
            d    = (c >= 2 * FP) ? b_pat(m_row(c)) : a_pat(m_row(c));
            rdy  = !(c >= FP && c < 2 * FP);
            want = m_out(c, d, rdy);
            n_chk++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL commit_on_wrap c=%0d got %h want %h",
                         c, obs, want);
            end
            if (c >= 4 && c <= 10) begin
                drive_wr(1'b1, row_t'(c - 4), b_pat(c - 4), 1'b0);
            end else if (c == FP - 1) begin
                drive_wr(1'b1, 3'd7, b_pat(7), 1'b1);
            end else begin
                drive_wr(1'b0, '0, '0, 1'b0);
            end
        end
    endtask

    task automatic test_scan_drop();
        logic [13:0] want;
        start_scan();
        for (int c = 0; c <= 5 * RP + 3; c++) begin
            step();
            want = m_out(c, b_pat(m_row(c)), 1'b1);
            n_chk++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL drop_pre c=%0d got %h want %h", c, obs, want);
            end
        end
        scan_en = 1'b0;
        step();
        n_chk++;
        if (obs !== 14'h0001) begin
            n_fail++;
            $display("FAIL drop_idle got %h want %h", obs, 14'h0001);
        end
        step();
        n_chk++;
        if (obs !== 14'h0001) begin
            n_fail++;
            $display("FAIL drop_hold got %h want %h", obs, 14'h0001);
        end
        scan_en = 1'b1;
        for (int c = 0; c < RP + 3; c++) begin
            step();
            want = m_out(c, b_pat(m_row(c)), 1'b1);
            n_chk++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL drop_restart c=%0d got %h want %h",
                         c, obs, want);
            end
        end
    endtask

    task automatic test_idle_commit();
        logic [13:0] want;
        scan_en = 1'b0;
        step();
        drive_wr(1'b1, 3'd2, 8'h5A, 1'b1);
        step();
        n_chk++;
        if (wif.wr_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_commit_busy got %b want 0", wif.wr_ready_o);
        end
        drive_wr(1'b0, '0, '0, 1'b0);
        step();
        n_chk++;
        if (wif.wr_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_commit_ready got %b want 1", wif.wr_ready_o);
        end
        scan_en = 1'b1;
        for (int c = 0; c < FP; c++) begin
            step();
            want = m_out(c, c_pat(m_row(c)), 1'b1);
            n_chk++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL idle_commit_show c=%0d got %h want %h",
                         c, obs, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] want;
        start_scan();
        for (int c = 0; c <= 20; c++) begin
            step();
            want = m_out(c, c_pat(m_row(c)), !(c >= 6));
            n_chk++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL reset_mid_pre c=%0d got %h want %h",
                         c, obs, want);
            end
            if (c == 5) begin
                drive_wr(1'b1, 3'd1, 8'hFF, 1'b1);
            end else begin
                drive_wr(1'b0, '0, '0, 1'b0);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== 14'h0001) begin
            n_fail++;
            $display("FAIL reset_mid_async got %h want %h", obs, 14'h0001);
        end
        scan_en = 1'b0;
        #2;
        rst_n = 1'b1;
        start_scan();
        for (int c = 0; c < FP; c++) begin
            step();
            want = m_out(c, 8'h00, 1'b1);
            n_chk++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL reset_mid_clear c=%0d got %h want %h",
                         c, obs, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_frame_write();
        test_commit_on_wrap();
        test_scan_drop();
        test_idle_commit();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_matrix_scan.md
Name: led_matrix_scan

Overview:
- Row-scan driver for the 8x8 LED matrix.
- Sits directly upstream of the 3-to-8 row decoder: produces the 3-bit row index and decoder enable that the decoder consumes, plus the column data for the active row.
- Holds a double-buffered (ping-pong) frame store. Frames arrive through a valid/ready row-write interface and are swapped in only at frame boundaries, so the display never tears.
- Inserts a blanking gap between rows to suppress ghosting.

Parameters:
- DWELL_CYCLES, 1000, clock cycles each row is lit (decoder enabled); legal range >=1.
- BLANK_CYCLES, 16, clock cycles of blanking before each row; legal range >=1.
- CNT_W, $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1), width of the shared phase counter (derived; not overridden).

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  asynchronous active-low reset.
- scan_en_i  input  1  enables scanning; low forces IDLE.
- wr_valid_i  input  1  row write request.
- wr_ready_o  output  1  back buffer accepts writes.
- wr_row_i  input  3  row index of the write.
- wr_data_i  input  `MATRIX_SIZE  column bits for that row (bit n = column n, 1 = lit).
- wr_last_i  input  1  commits the back buffer as a complete frame; qualified by the handshake.
- row_sel_o  output  3  row index to the decoder.
- decoder_en_o  output  1  decoder enable; high only while a row is lit.
- col_data_o  output  `MATRIX_SIZE  column drive for the current row (active high).
- frame_start_o  output  1  one-cycle pulse on the first lit cycle of row 0.

Behaviour:
- Clock and reset: single clock, clk_i. Reset is asynchronous and active-low on rst_n_i.
- Reset values: state=IDLE; row_sel_o=0; decoder_en_o=0; col_data_o=0; frame_start_o=0; wr_ready_o=1; both buffers all-zero; display pointer=0; pending=0; counter=0.
- Write handshake: a write is accepted when wr_valid_i && wr_ready_o.
  - An accepted write stores wr_data_i into back[wr_row_i] on that edge.
  - If wr_last_i is also high, pending is set on the next edge.
  - wr_ready_o = !pending (registered).
- States:
  - IDLE: decoder_en_o=0, col_data_o=0, row_sel_o=0.
    - If pending, the swap happens on the next edge.
    - When scan_en_i=1, go to BLANK with row=0 and counter=0.
  - BLANK: decoder_en_o=0, col_data_o=0, row_sel_o holds the upcoming row.
    - Counter runs 0..BLANK_CYCLES-1.
    - On the last count, go to DISPLAY and clear the counter.
  - DISPLAY: decoder_en_o=1, row_sel_o=row, col_data_o=display[row] (registered, valid in the same cycle decoder_en_o rises).
    - Counter runs 0..DWELL_CYCLES-1.
    - On the last count: row <= row+1 (7 wraps to 0), go to BLANK.
- Timing:
  - Row period = BLANK_CYCLES + DWELL_CYCLES.
  - Frame period = 8 x row period.
  - First lit cycle occurs BLANK_CYCLES+1 cycles after scan_en_i is sampled high in IDLE.
- Frame swap: on the DISPLAY->BLANK edge where row wraps 7->0, if pending, toggle the display pointer and clear pending.
  - After a swap, the new back buffer holds stale data; the writer must rewrite all rows it cares about.
- frame_start_o pulses on the first DISPLAY cycle of row 0, including after scan start.
- Simultaneous events:
  - wr_last accepted on the same edge as a wrap: that commit misses this swap and waits for the next wrap (pending is sampled before the update).
  - Write to a row while it is displayed: no effect on the display; only the back buffer changes.
- scan_en_i low in any state: next edge enters IDLE, outputs go to the IDLE values, row and counter clear. Pending is kept.
- Reset mid-frame: immediate return to reset values; any partially written frame is lost.
- Invariant: decoder_en_o is never high while row_sel_o changes. row_sel_o only updates on the DISPLAY->BLANK edge.

Decomposition:
- Shared package/defines:
  - `MATRIX_SIZE (8)
  - ROW_W (3)
  - scan state encoding: IDLE=2'd0, BLANK=2'd1, DISPLAY=2'd2
- One sub-module, led_frame_buffer:
  - two 8x`MATRIX_SIZE register banks with a ping-pong pointer
  - write port (row, data, en)
  - swap input
  - combinational read of the display bank by row
- The FSM, counter and handshake remain in led_matrix_scan.

Test Plan:
- Reset then scan_en_i=1 with DWELL=4, BLANK=2 → decoder_en_o first high 3 cycles later, row_sel_o sequence 0..7..0, each lit for 4 cycles and separated by 2 blank cycles; col_data_o=0 throughout (empty buffers).
- Write rows 0..7 with 8'h01<<row, last on row 7, during row 3 of a scan → wr_ready_o=0 next cycle; col_data_o stays 0 until the row-0 DISPLAY after the wrap, then shows 8'h01,8'h02,..,8'h80; frame_start_o pulses once; wr_ready_o returns to 1.
- wr_last accepted on the exact wrap edge → no swap this frame; swap at the following wrap; pending held for exactly one frame.
- scan_en_i dropped during DISPLAY of row 5 → next cycle decoder_en_o=0, col_data_o=0, row_sel_o=0. Re-enabling starts at row 0 after 2 blank cycles, with frame_start_o pulsing.
- Commit a frame while in IDLE → swap on the next edge; wr_ready_o=1 again two cycles after the commit.
- Assert rst_n_i low mid-DISPLAY → all outputs 0 asynchronously and buffers cleared; wr_ready_o=1 after release.
